demux_1to16_reg: RTL and testbench
==================================

DEMUX_1TO16_REG -- requirements
Module: demux_1to16_reg

Interface
REQ-001 SHALL have parameter N_OUT, default 16, meaning number of output lanes (fixed 16 in this release).
REQ-002 SHALL have parameter SEL_W, default 2, meaning width of each select field.
REQ-003 SHALL have port clk  input  1  sole clock; all state updates on its rising edge.
REQ-004 SHALL have port rst  input  1  reset, synchronous, active-high.
REQ-005 SHALL have port in  input  1  data bit to route.
REQ-006 SHALL have port in_valid  input  1  qualifies in/s1/s2 this cycle.
REQ-007 SHALL have port s1  input  2  column select (low index bits) in addressed mode.
REQ-008 SHALL have port s2  input  2  row select (high index bits) in addressed mode.
REQ-009 SHALL have port auto  input  1  1 = internal pointer selects lane, s1/s2 ignored.
REQ-010 SHALL have port clear  input  1  zero all lanes, pointer and pipeline.
REQ-011 SHALL have port out  output  16  registered lane outputs.
REQ-012 SHALL have port ptr  output  4  current auto-mode pointer.
REQ-013 SHALL have port word_done  output  1  one-cycle pulse, lane 15 written in auto mode.

Function
REQ-014 SHALL map an accepted bit to lane index {s2,s1}, i.e. out[4*s2+s1], in addressed mode.
REQ-015 SHALL map an accepted bit to lane index ptr in auto mode.
REQ-016 SHALL be a 2-stage pipeline: stage 1 registers in, valid and resolved 4-bit index; stage 2 writes the bit into out.
REQ-017 SHALL update out exactly 2 cycles after the in_valid edge; non-addressed lanes hold their value.
REQ-018 SHALL accept one bit per cycle with no backpressure; back-to-back in_valid is legal.
REQ-019 SHALL increment ptr by 1 modulo 16 on each accepted bit in auto mode; 15 wraps to 0.
REQ-020 SHALL hold ptr while auto=0 and reset ptr to 0 in the cycle after auto rises 0->1.
REQ-021 SHALL assert word_done for one cycle, coincident with the out update, when an auto-mode bit lands on lane 15.
REQ-022 SHALL, on clear=1, zero out, ptr, word_done and both pipeline valid flags on the next edge; bits in flight are discarded.
REQ-023 SHALL give clear priority over a simultaneous in_valid; that bit is dropped.
REQ-024 SHALL resolve the stage-1 index at acceptance time; later changes of auto/s1/s2 do not redirect bits in flight.
REQ-025 SHALL ignore in, s1, s2 when in_valid=0.

Reset
REQ-026 SHALL, with rst=1 at a clk edge, set out=16'h0000, ptr=0, word_done=0 and clear all pipeline valid and auto-history flags.
REQ-027 SHALL give rst priority over clear and in_valid; a reset mid-word discards the partial word.
REQ-028 SHALL produce the first possible out update 2 cycles after the first in_valid following rst deassertion.

Structure
REQ-029 SHALL place N_OUT, SEL_W and the 4-bit lane-index width in a shared package.
REQ-030 SHALL instantiate sub-module demux_1to4 (2-bit select to 4-bit one-hot enable) twice, row then column, ANDed to form the 16 lane write enables.

Verification
REQ-031 SHALL cover: reset, then addressed s2=2, s1=1, in=1, in_valid pulse -> out=16'h0200 two cycles later, all other lanes 0.
REQ-032 SHALL cover: auto=1, 16 back-to-back valid bits pattern 16'hA5C3 LSB first -> out=16'hA5C3, word_done high one cycle, ptr=0.
REQ-033 SHALL cover: auto=1, 20 valid bits -> ptr wraps, lanes 0..3 overwritten, second word_done absent until bit 32.
REQ-034 SHALL cover: clear and in_valid same cycle with out=16'hFFFF -> out=16'h0000 next cycle, dropped bit never appears.
REQ-035 SHALL cover: rst asserted after 7 auto bits -> out=0, ptr=0; next 16 bits assemble a full word from lane 0.
REQ-036 SHALL cover: s1/s2 change the cycle after acceptance -> bit lands at the originally selected lane.

Source files
------------

// File: rtl/demux_1to16_reg_pkg.sv
// rtl/demux_1to16_reg_pkg.sv - shared sizes and stage-1 record for the 1-to-16 registered demux
package demux_1to16_reg_pkg;

    localparam int DEF_N_OUT = 16;
    localparam int DEF_SEL_W = 2;
    localparam int IDX_W     = 4;

    typedef struct packed {
        logic             valid;
        logic             data;
        logic             auto_mode;
        logic [IDX_W-1:0] idx;
    } stage1_t;

endpackage

// File: rtl/demux_1to4.sv
// rtl/demux_1to4.sv - 2-bit select to 4-bit one-hot enable
module demux_1to4
    import demux_1to16_reg_pkg::*;
(
    input  logic [DEF_SEL_W-1:0] sel_i,
    input  logic                 en_i,
    output logic [3:0]           onehot_o
);

    always_comb begin
        onehot_o        = '0;
        onehot_o[sel_i] = en_i;
    end

endmodule

// File: rtl/demux_1to16_reg.sv
// rtl/demux_1to16_reg.sv - two-stage registered 1-to-16 bit demux with addressed and auto-pointer modes
module demux_1to16_reg
    import demux_1to16_reg_pkg::*;
#(
    parameter int N_OUT = DEF_N_OUT,
    parameter int SEL_W = DEF_SEL_W
)
(
    input  logic             clk,
    input  logic             rst,
    input  logic             in,
    input  logic             in_valid,
    input  logic [SEL_W-1:0] s1,
    input  logic [SEL_W-1:0] s2,
    input  logic             auto,
    input  logic             clear,
    output logic [N_OUT-1:0] out,
    output logic [IDX_W-1:0] ptr,
    output logic             word_done
);

    stage1_t          s1_q, s1_d;
    logic [IDX_W-1:0] ptr_q, ptr_d, base;
    logic             auto_q;
    logic [N_OUT-1:0] out_q, out_d, we;
    logic             wd_q, wd_d;
    logic [3:0]       row_en, col_en;

    // A fresh entry into auto mode restarts the pointer at lane 0.
    always_comb begin
        base         = auto_q ? ptr_q : '0;
        ptr_d        = ptr_q;
        if (auto) begin
            ptr_d = in_valid ? base + IDX_W'(1) : base;
        end
        s1_d.valid     = in_valid;
        s1_d.data      = in;
        s1_d.auto_mode = auto;
        s1_d.idx       = auto ? base : {s2, s1};
    end

    demux_1to4 u_row (
        .sel_i    (s1_q.idx[3:2]),
        .en_i     (s1_q.valid),
        .onehot_o (row_en)
    );

    demux_1to4 u_col (
        .sel_i    (s1_q.idx[1:0]),
        .en_i     (1'b1),
        .onehot_o (col_en)
    );

    for (genvar r = 0; r < 4; r++) begin : g_row
        for (genvar c = 0; c < 4; c++) begin : g_col
            assign we[r*4+c] = row_en[r] & col_en[c];
        end
    end

    always_comb begin
        out_d = out_q;
        for (int i = 0; i < N_OUT; i++) begin
            if (we[i]) begin
                out_d[i] = s1_q.data;
            end
        end
        wd_d = s1_q.valid && s1_q.auto_mode && (s1_q.idx == IDX_W'(N_OUT - 1));
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            s1_q   <= '0;
            ptr_q  <= '0;
            auto_q <= 1'b0;
            out_q  <= '0;
            wd_q   <= 1'b0;
        end else if (clear) begin
            s1_q   <= '0;
            ptr_q  <= '0;
            auto_q <= auto;
            out_q  <= '0;
            wd_q   <= 1'b0;
        end else begin
            s1_q   <= s1_d;
            ptr_q  <= ptr_d;
            auto_q <= auto;
            out_q  <= out_d;
            wd_q   <= wd_d;
        end
    end

    assign out       = out_q;
    assign ptr       = ptr_q;
    assign word_done = wd_q;

endmodule

// File: tb/tb_demux_1to16_reg.sv
// tb/tb_demux_1to16_reg.sv - scoreboard bench for demux_1to16_reg
module tb_demux_1to16_reg;

    logic        clk = 1'b0;
    logic        t_rst = 1'b1, t_in = 1'b0, t_valid = 1'b0, t_auto = 1'b0, t_clear = 1'b0;
    logic [1:0]  t_s1 = 2'd0, t_s2 = 2'd0;
    logic [15:0] d_out;
    logic [3:0]  d_ptr;
    logic        d_wd;

    demux_1to16_reg dut (
        .clk       (clk),
        .rst       (t_rst),
        .in        (t_in),
        .in_valid  (t_valid),
        .s1        (t_s1),
        .s2        (t_s2),
        .auto      (t_auto),
        .clear     (t_clear),
        .out       (d_out),
        .ptr       (d_ptr),
        .word_done (d_wd)
    );

    always #5 clk = ~clk;

    typedef struct {
        int          cyc;
        logic [15:0] out;
        logic [3:0]  ptr;
        logic        wd;
        logic        chk_ptr;
        logic [63:0] tag;
    } exp_t;

    exp_t        sb[$];
    int          cyc = 0;
    int          n_pass = 0;
    int          n_total = 0;

    logic [15:0] m_out = '0;
    logic [3:0]  m_ptr = '0;
    logic        m_autoq = 1'b0;

    always @(posedge clk) cyc++;

    always @(negedge clk) begin
        exp_t e;
        while (sb.size() > 0 && sb[0].cyc <= cyc) begin
            e = sb.pop_front();
            n_total++;
            if (d_out !== e.out)
                $display("FAIL %0s out @%0d: got %h expected %h", e.tag, cyc, d_out, e.out);
            else
                n_pass++;
            n_total++;
            if (d_wd !== e.wd)
                $display("FAIL %0s word_done @%0d: got %b expected %b", e.tag, cyc, d_wd, e.wd);
            else
                n_pass++;
            if (e.chk_ptr) begin
                n_total++;
                if (d_ptr !== e.ptr)
                    $display("FAIL %0s ptr @%0d: got %0d expected %0d", e.tag, cyc, d_ptr, e.ptr);
                else
                    n_pass++;
            end
        end
    end

    task automatic push(input int c, input logic [15:0] o, input logic [3:0] p,
                        input logic w, input logic cp, input logic [63:0] tag);
        exp_t e;
        e.cyc = c; e.out = o; e.ptr = p; e.wd = w; e.chk_ptr = cp; e.tag = tag;
        sb.push_back(e);
    endtask

    task automatic drive(input logic r, input logic c, input logic v, input logic d,
                         input logic a, input logic [1:0] s2v, input logic [1:0] s1v);
        int         k;
        logic [3:0] idx, base;
        k = cyc + 1;
        t_rst = r; t_clear = c; t_valid = v; t_in = d; t_auto = a; t_s2 = s2v; t_s1 = s1v;
        if (r || c) begin
            while (sb.size() > 0 && sb[$].cyc >= k) void'(sb.pop_back());
            m_out = '0; m_ptr = '0; m_autoq = r ? 1'b0 : a;
            push(k, 16'h0000, 4'd0, 1'b0, 1'b1, r ? "rst" : "clear");
        end else begin
            idx = {s2v, s1v};
            if (a) begin
                base = m_autoq ? m_ptr : 4'd0;
                if (v) begin
                    idx = base;
                    m_ptr = base + 4'd1;
                end else begin
                    m_ptr = base;
                end
            end
            if (v) begin
                m_out[idx] = d;
                push(k + 1, m_out, 4'd0, a && idx == 4'd15, 1'b0, "land");
            end
            m_autoq = a;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) drive(0, 0, 0, 0, t_auto, 0, 0);
    endtask

    task automatic check_now(input logic [63:0] tag, input logic [15:0] o, input logic [3:0] p);
        push(cyc, o, p, 1'b0, 1'b1, tag);
    endtask

    task automatic auto_word(input logic [15:0] w, input int nbits);
        for (int i = 0; i < nbits; i++) drive(0, 0, 1, w[i % 16], 1, 0, 0);
    endtask

    logic [15:0] pat;

    initial begin
        drive(1, 0, 0, 0, 0, 0, 0);
        drive(1, 0, 0, 0, 0, 0, 0);
        idle(1);
        check_now("reset", 16'h0000, 4'd0);

        drive(0, 0, 1, 1, 0, 2'd2, 2'd1);
        idle(3);
        check_now("addr", 16'h0200, 4'd0);

        drive(0, 1, 0, 0, 0, 0, 0);
        auto_word(16'hA5C3, 16);
        idle(3);
        check_now("word", 16'hA5C3, 4'd0);

        auto_word(16'h1234, 16);
        pat = 16'h0005;
        for (int i = 0; i < 4; i++) drive(0, 0, 1, pat[i], 1, 0, 0);
        idle(3);
        check_now("wrap", 16'h1235, 4'd4);

        for (int i = 0; i < 16; i++) drive(0, 0, 1, 1, 0, 2'(i >> 2), 2'(i & 3));
        idle(3);
        check_now("hold", 16'hFFFF, 4'd4);
        drive(0, 1, 1, 1, 0, 2'd1, 2'd1);
        idle(3);
        check_now("clrdrop", 16'h0000, 4'd0);

        auto_word(16'hFFFF, 7);
        drive(1, 0, 0, 0, 1, 0, 0);
        auto_word(16'h5A3C, 16);
        idle(3);
        check_now("rstword", 16'h5A3C, 4'd0);

        drive(0, 1, 0, 0, 0, 0, 0);
        drive(0, 0, 1, 1, 0, 2'd3, 2'd2);
        drive(0, 0, 0, 0, 0, 2'd0, 2'd0);
        drive(0, 0, 0, 1, 0, 2'd1, 2'd1);
        idle(3);
        check_now("inflight", 16'h4000, 4'd0);

        idle(3);
        n_total++;
        if (sb.size() != 0)
            $display("FAIL drain: got %0d pending expected 0", sb.size());
        else
            n_pass++;
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
